fp_recip_scheduler: RTL
=======================

Name: fp_recip_scheduler

Overview:
- Shares one combinational FP12 (E5M6) -> FP16 (E5M10) reciprocal unit among NUM_REQ requesters.
- Performs round-robin arbitration, a 2-stage registered pipeline with full backpressure, and resolution of the special operands (inf, NaN, zero) that the reciprocal LUT path does not handle.
- Sits between the per-lane ALU issue logic and the shared divider resource.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- TAG_W, 4, opaque tag width carried alongside each request.
- SRC_W, $clog2(NUM_REQ), derived, requester-index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept
- req_operand  in  NUM_REQ*12  packed FP12 divisors, requester i at [12*i+:12]
- req_tag  in  NUM_REQ*TAG_W  packed tags
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accept
- rsp_result  out  16  FP16 reciprocal
- rsp_src  out  SRC_W  index of the originating requester
- rsp_tag  out  TAG_W  tag echoed from the request
- stat_issued  out  32  accepted-request count (optional feature)
- stat_stall  out  32  stall-cycle count (optional feature)

Interface: one clock, clk; reset rst_n is asynchronous, active-low.

Behaviour:
- Reset:
  - s1_valid = s2_valid = 0; rr pointer = NUM_REQ-1, so requester 0 has first priority.
  - rsp_valid = 0; rsp_result, rsp_src, rsp_tag, stat_* = 0; req_ready = 0 while rst_n is low.
- Pipeline control:
  - adv2 = !s2_valid | rsp_ready.
  - adv1 = !s1_valid | adv2.
- Arbiter:
  - Combinational round-robin search, starting at ptr+1 and wrapping modulo NUM_REQ.
  - req_ready[g] = adv1 for the granted index g only; all other req_ready bits are 0.
  - req_ready never depends on the same requester's req_valid beyond the grant search (no combinational loop on ready).
- Accept: a request is accepted when req_valid[g] & req_ready[g].
  - S1 captures operand, tag and g; s1_valid <= 1.
  - ptr <= g. The pointer updates only on accept.
- No request but adv1 high: s1_valid <= 0.
- S1 -> S2 transfer on adv2: S2 captures the reciprocal, src and tag; s2_valid <= s1_valid.
- Latency: accept at cycle N -> rsp_valid at N+2 when there is no backpressure. Throughput is 1 per cycle.
- Reciprocal of FP12 {s,e,m}:
  - e=0, m=0: {s,15'h7C00} (±inf).
  - e=31, m=0: {s,15'h0} (±0).
  - e=31, m!=0: 16'h7E00 (canonical qNaN; sign ignored).
  - Otherwise: the output of the LUT reciprocal sub-unit, unmodified.
- Holding: rsp_* hold stable while rsp_valid & !rsp_ready; S1 holds while stalled.
- Simultaneous drain and accept in the same cycle is legal: a full pipeline keeps 1 op/cycle.
- A requester that deasserts req_valid before being granted loses nothing; no state is kept per requester.
- Asynchronous reset mid-operation discards in-flight S1/S2 contents; no partial response is emitted.

Optional Feature:
- Macro: FP_RECIP_SCHED_STATS_EN.
- Defined:
  - stat_issued increments on every accept.
  - stat_stall increments each cycle where rsp_valid & !rsp_ready.
  - Both are 32-bit, saturate at 32'hFFFF_FFFF, and reset to 0.
- Undefined: both ports are driven constant 0 and no counter flops are synthesized.

Decomposition:
- Package fp_recip_pkg:
  - FP12 field widths/offsets (sign 11, exp 10:6, mant 5:0).
  - FP12_EXP_MAX=5'h1F.
  - FP16_POS_INF=16'h7C00, FP16_QNAN=16'h7E00.
  - Response struct {result, src, tag}.
- Sub-module fp_recip_rr_arbiter: NUM_REQ-wide round-robin grant with pointer register and update-on-accept input.
- The LUT reciprocal unit is instantiated as-is inside stage 1.

Test Plan:
- Single requester 0, operand 12'h3C0 (1.0), tag 3, rsp_ready=1 -> rsp_result 16'h3C00, rsp_src 0, rsp_tag 3, exactly 2 cycles after accept.
- Operands 12'h400 (2.0) and 12'hC00 (-2.0) -> 16'h3800 and 16'hB800.
- Special cases:
  - 12'h7C0 -> 16'h0000.
  - 12'hFC0 -> 16'h8000.
  - 12'h7C1 -> 16'h7E00.
  - 12'h000 -> 16'h7C00.
  - 12'h800 -> 16'hFC00.
- All 4 requesters valid continuously -> grants in order 0,1,2,3,0,…; responses back-to-back, one per cycle, with matching rsp_src/tag.
- rsp_ready held low 5 cycles with the pipe full:
  - rsp_* stay stable and req_ready goes 0.
  - On release, no loss or duplication occurs.
  - stat_stall = 5 (STATS_EN defined).
- rst_n asserted asynchronously with two ops in flight -> rsp_valid drops immediately, req_ready = 0; after release, the first grant goes to requester 0 and no stale response appears.

Source files
------------

// File: rtl/fp_recip_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_recip_pkg
//  Description : Shared definitions for the FP12 -> FP16 reciprocal scheduler.
//                FP12 is E5M6 (bias 15), FP16 is E5M10 (bias 15).
//                Field layout of FP12: sign [11], exponent [10:6],
//                mantissa [5:0].
//  Revision    : 1.0  initial release
// ============================================================================
package fp_recip_pkg;

   localparam int FP12_W        = 12;
   localparam int FP12_SIGN_BIT = 11;
   localparam int FP12_EXP_HI   = 10;
   localparam int FP12_EXP_LO   = 6;
   localparam int FP12_MANT_HI  = 5;
   localparam int FP12_MANT_LO  = 0;

   localparam logic [4:0]  FP12_EXP_MAX = 5'h1F;
   localparam logic [15:0] FP16_POS_INF = 16'h7C00;
   localparam logic [15:0] FP16_QNAN    = 16'h7E00;

   typedef struct packed {
      logic       sign;
      logic [4:0] exp;
      logic [5:0] mant;
   } fp12_t;

endpackage : fp_recip_pkg
`default_nettype wire

// File: rtl/fp_recip_lut.sv
`default_nettype none
// ============================================================================
//  Module      : fp_recip_lut
//  Description : Combinational FP12 -> FP16 reciprocal, table based.
//                Normal and subnormal FP12 inputs are handled; results that
//                overflow become inf, tiny results become FP16 subnormals.
//                Inf/NaN/zero inputs are not meaningful here and are
//                resolved by the caller.
//  Ports       : operand (FP12 in), result (FP16 out)
//  Revision    : 1.0  initial release
// ============================================================================
module fp_recip_lut
   import fp_recip_pkg::*;
(
   input  logic [11:0] operand,
   output logic [15:0] result
);

   fp12_t              op;
   logic [14:0]        rom [0:63];
   logic [2:0]         lead;
   logic [5:0]         mn;
   logic signed [7:0]  ee;
   logic signed [7:0]  ex;
   logic [14:0]        v;
   logic [9:0]         sig_n;
   logic [9:0]         sig_s0;
   logic [9:0]         sig_s1;

   assign op = fp12_t'(operand);

   // rom[m] = floor(2^20 / (64+m)): the reciprocal of 1.m with 3 spare bits
   // below the FP16 LSB. Entry 0 is 1.0 (the exact 2^13 scale) so that the
   // exponent bookkeeping below treats a zero fraction separately.
   genvar i;
   generate
      for (i = 0; i < 64; i++) begin : g_rom
         localparam logic [14:0] ROM_VAL = (i == 0) ? 15'd8192 :
                                           15'((32'd1 << 20) / (32'd64 + 32'(i)));
         assign rom[i] = ROM_VAL;
      end
   endgenerate

   // Subnormal inputs are renormalised so the table sees a 1.f value.
   always_comb begin
      lead = 3'd0;
      for (int k = 0; k < 6; k++) begin
         if (op.mant[k]) lead = 3'(k);
      end
      if (op.exp == 5'd0) begin
         mn = 6'(op.mant << (3'd6 - lead));
         ee = $signed({5'd0, lead}) - 8'sd5;
      end else begin
         mn = op.mant;
         ee = $signed({3'd0, op.exp});
      end
      ex = (mn == 6'd0) ? (8'sd30 - ee) : (8'sd29 - ee);
   end

   assign v = rom[mn];

   // Adding half an output LSB before truncating gives round-to-nearest;
   // the quotient 2^k/(64+m) is never exactly halfway, so no tie handling.
   assign sig_n  = 10'((v + 15'd4)  >> 3);
   assign sig_s0 = 10'((v + 15'd8)  >> 4);
   assign sig_s1 = 10'((v + 15'd16) >> 5);

   always_comb begin
      if (ex > 8'sd30)
         result = {op.sign, FP16_POS_INF[14:0]};
      else if (ex >= 8'sd1)
         result = {op.sign, ex[4:0], sig_n};
      else if (ex == 8'sd0)
         result = {op.sign, 5'd0, sig_s0};
      else if (ex == -8'sd1)
         result = {op.sign, 5'd0, sig_s1};
      else
         result = {op.sign, 15'd0};
   end

endmodule : fp_recip_lut
`default_nettype wire

// File: rtl/fp_recip_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fp_recip_rr_arbiter
//  Description : Round-robin grant among NUM_REQ requesters. The search
//                starts one past the last accepted index and wraps; the
//                pointer moves only when the granted request is accepted.
//  Ports       : clk, rst_n, req (valids), update (accept strobe),
//                grant (one-hot, zero when idle), grant_idx
//  Revision    : 1.0  initial release
// ============================================================================
module fp_recip_rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int SRC_W   = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               update,
   output logic [NUM_REQ-1:0] grant,
   output logic [SRC_W-1:0]   grant_idx
);

   logic [SRC_W-1:0] ptr;
   logic [SRC_W-1:0] idx;
   logic             found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = SRC_W'((int'(ptr) + i) % NUM_REQ);
         if (!found && req[idx]) begin
            found     = 1'b1;
            grant_idx = idx;
         end
      end
      if (found) grant[grant_idx] = 1'b1;
   end

   // Reset to the last index so requester 0 wins the first search.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ptr <= SRC_W'(NUM_REQ - 1);
      else if (update)
         ptr <= grant_idx;
   end

endmodule : fp_recip_rr_arbiter
`default_nettype wire

// File: rtl/fp_recip_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : fp_recip_scheduler
//  Description : Shares one FP12 -> FP16 reciprocal unit among NUM_REQ
//                requesters. Round-robin arbitration, 2-stage pipeline with
//                full backpressure, special-operand resolution (inf/NaN/0).
//                Optional statistics counters: FP_RECIP_SCHED_STATS_EN.
//  Ports       : clk, rst_n (async, active-low)
//                req_valid/req_ready/req_operand/req_tag  request side
//                rsp_valid/rsp_ready/rsp_result/rsp_src/rsp_tag  response
//                stat_issued, stat_stall  counters (0 when feature absent)
//  Revision    : 1.0  initial release
// ============================================================================
module fp_recip_scheduler
   import fp_recip_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int TAG_W   = 4,
   localparam int SRC_W   = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*12-1:0]    req_operand,
   input  logic [NUM_REQ*TAG_W-1:0] req_tag,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [15:0]              rsp_result,
   output logic [SRC_W-1:0]         rsp_src,
   output logic [TAG_W-1:0]         rsp_tag,
   output logic [31:0]              stat_issued,
   output logic [31:0]              stat_stall
);

   typedef struct packed {
      logic [15:0]      result;
      logic [SRC_W-1:0] src;
      logic [TAG_W-1:0] tag;
   } rsp_t;

   logic               adv1, adv2, accept;
   logic [NUM_REQ-1:0] grant;
   logic [SRC_W-1:0]   grant_idx;
   logic [11:0]        sel_operand;
   logic [TAG_W-1:0]   sel_tag;

   logic               s1_valid;
   logic [11:0]        s1_operand;
   logic [SRC_W-1:0]   s1_src;
   logic [TAG_W-1:0]   s1_tag;
   logic [15:0]        lut_result;
   logic [15:0]        s1_result;

   logic               s2_valid;
   rsp_t               s2_rsp;

   assign adv2 = !s2_valid || rsp_ready;
   assign adv1 = !s1_valid || adv2;

   fp_recip_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req_valid),
      .update    (accept),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // Ready is the grant qualified by pipeline space; it never feeds back
   // into the grant search. Held low while reset is asserted.
   assign req_ready = rst_n ? (grant & {NUM_REQ{adv1}}) : '0;
   assign accept    = |(req_valid & req_ready);

   always_comb begin
      sel_operand = '0;
      sel_tag     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_operand = req_operand[12*i +: 12];
            sel_tag     = req_tag[TAG_W*i +: TAG_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid   <= 1'b0;
         s1_operand <= '0;
         s1_src     <= '0;
         s1_tag     <= '0;
      end else if (adv1) begin
         s1_valid <= accept;
         if (accept) begin
            s1_operand <= sel_operand;
            s1_src     <= grant_idx;
            s1_tag     <= sel_tag;
         end
      end
   end

   fp_recip_lut u_lut (
      .operand (s1_operand),
      .result  (lut_result)
   );

   // Exponent all-ones: inf -> signed zero, NaN -> canonical qNaN.
   // Zero -> signed inf. Everything else comes straight from the table.
   always_comb begin
      s1_result = lut_result;
      if (s1_operand[FP12_EXP_HI:FP12_EXP_LO] == FP12_EXP_MAX) begin
         if (s1_operand[FP12_MANT_HI:FP12_MANT_LO] == '0)
            s1_result = {s1_operand[FP12_SIGN_BIT], 15'h0000};
         else
            s1_result = FP16_QNAN;
      end else if (s1_operand[FP12_EXP_HI:FP12_MANT_LO] == '0) begin
         s1_result = {s1_operand[FP12_SIGN_BIT], FP16_POS_INF[14:0]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_rsp   <= '0;
      end else if (adv2) begin
         s2_valid <= s1_valid;
         if (s1_valid) s2_rsp <= '{result: s1_result, src: s1_src, tag: s1_tag};
      end
   end

   assign rsp_valid  = s2_valid;
   assign rsp_result = s2_rsp.result;
   assign rsp_src    = s2_rsp.src;
   assign rsp_tag    = s2_rsp.tag;

`ifdef FP_RECIP_SCHED_STATS_EN
   logic [31:0] issued_cnt;
   logic [31:0] stall_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issued_cnt <= '0;
         stall_cnt  <= '0;
      end else begin
         if (accept && (issued_cnt != 32'hFFFF_FFFF))
            issued_cnt <= issued_cnt + 32'd1;
         if (s2_valid && !rsp_ready && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
      end
   end

   assign stat_issued = issued_cnt;
   assign stat_stall  = stall_cnt;
`else
   assign stat_issued = '0;
   assign stat_stall  = '0;
`endif

endmodule : fp_recip_scheduler
`default_nettype wire
